// File: rtl/hmmm_sram_ctrl.sv
// Two-phase asynchronous-SRAM controller: inputs are sampled on ph2, and state
// and all outputs update on ph1 from those sampled values.
module hmmm_sram_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                  ph1,
  input  logic                  ph2,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  done,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [ADDR_WIDTH-1:0] sram_adr,
  output logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  sram_doe,
  input  logic [DATA_WIDTH-1:0] sram_din
);

  localparam int unsigned CNT_W = 4;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_ACCESS = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_TURN   = 3'd4;

  if (WAIT_CYCLES > 15) begin : g_wait_range
    $error("hmmm_sram_ctrl: WAIT_CYCLES must be in 0..15");
  end

  // ph2 input samples
  logic                  samp_reset_q;
  logic                  samp_req_q;
  logic                  samp_wr_q;
  logic [ADDR_WIDTH-1:0] samp_addr_q;
  logic [DATA_WIDTH-1:0] samp_wdata_q;
  logic [DATA_WIDTH-1:0] samp_din_q;

  always_ff @(posedge ph2) begin
    samp_reset_q <= reset;
    samp_req_q   <= req;
    samp_wr_q    <= wr;
    samp_addr_q  <= addr;
    samp_wdata_q <= wdata;
    samp_din_q   <= sram_din;
  end

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  done_q, done_d;
  logic                  ce_n_q, ce_n_d;
  logic                  oe_n_q, oe_n_d;
  logic                  we_n_q, we_n_d;
  logic                  doe_q, doe_d;
  logic                  accept;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    adr_d   = adr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    accept  = samp_req_q & ready_q;

    case (state_q)
      S_IDLE, S_TURN: begin
        state_d = S_IDLE;
        if (accept) begin
          wr_d   = samp_wr_q;
          adr_d  = samp_addr_q;
          dout_d = samp_wdata_q;
          if (samp_wr_q) begin
            state_d = S_SETUP;
          end else begin
            state_d = S_ACCESS;
            cnt_d   = CNT_W'(WAIT_CYCLES);
          end
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = CNT_W'(WAIT_CYCLES);
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          if (wr_q) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_TURN;
            rdata_d = samp_din_q;
          end
        end else begin
          cnt_d = CNT_W'(cnt_q - CNT_W'(1));
        end
      end
      default: state_d = S_IDLE;
    endcase

    // reset wins over any in-flight access and any request
    if (samp_reset_q) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      wr_d    = 1'b0;
      adr_d   = '0;
      dout_d  = '0;
      rdata_d = '0;
    end

    ready_d  = (state_d == S_IDLE) || (state_d == S_TURN);
    rvalid_d = (state_d == S_TURN);
    done_d   = (state_d == S_TURN) || (state_d == S_HOLD);
    ce_n_d   = !((state_d == S_SETUP) || (state_d == S_ACCESS) || (state_d == S_HOLD));
    we_n_d   = !((state_d == S_ACCESS) && wr_d);
    oe_n_d   = !((state_d == S_ACCESS) && !wr_d);
    doe_d    = (state_d == S_SETUP) || (state_d == S_HOLD) ||
               ((state_d == S_ACCESS) && wr_d);
  end

  always_ff @(posedge ph1) begin
    state_q  <= state_d;
    cnt_q    <= cnt_d;
    wr_q     <= wr_d;
    adr_q    <= adr_d;
    dout_q   <= dout_d;
    rdata_q  <= rdata_d;
    ready_q  <= ready_d;
    rvalid_q <= rvalid_d;
    done_q   <= done_d;
    ce_n_q   <= ce_n_d;
    oe_n_q   <= oe_n_d;
    we_n_q   <= we_n_d;
    doe_q    <= doe_d;
  end

  assign ready     = ready_q;
  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign done      = done_q;
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
  assign sram_adr  = adr_q;
  assign sram_dout = dout_q;
  assign sram_doe  = doe_q;

endmodule

// File: tb/tb_hmmm_sram_ctrl.sv
// Directed bench for hmmm_sram_ctrl: four instances (WAIT 1/0/3 and a 10x32 part)
// share req/wr/reset; each test checks one instance against hand-derived timing.
module tb_hmmm_sram_ctrl;

  logic ph1, ph2, reset, req, wr;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [9:0]  waddr;
  logic [31:0] wwdata;

  logic        ready_1, rvalid_1, done_1, ce_n_1, oe_n_1, we_n_1, doe_1;
  logic [7:0]  adr_1;
  logic [15:0] rdata_1, dout_1, din_1;
  logic        ready_0, rvalid_0, done_0, ce_n_0, oe_n_0, we_n_0, doe_0;
  logic [7:0]  adr_0;
  logic [15:0] rdata_0, dout_0, din_0;
  logic        ready_3, rvalid_3, done_3, ce_n_3, oe_n_3, we_n_3, doe_3;
  logic [7:0]  adr_3;
  logic [15:0] rdata_3, dout_3, din_3;
  logic        ready_w, rvalid_w, done_w, ce_n_w, oe_n_w, we_n_w, doe_w;
  logic [9:0]  adr_w;
  logic [31:0] rdata_w, dout_w, din_w;

  logic [15:0] mem1 [0:255];
  logic [15:0] mem0 [0:255];
  logic [15:0] mem3 [0:255];
  logic [31:0] memw [0:1023];

  int n_chk = 0;
  int n_err = 0;
  int viol  = 0;
  logic mon_en = 1'b0;

  hmmm_sram_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_CYCLES(1)) u_d1 (
    .ph1(ph1), .ph2(ph2), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .ready(ready_1), .rdata(rdata_1), .rvalid(rvalid_1), .done(done_1),
    .sram_ce_n(ce_n_1), .sram_oe_n(oe_n_1), .sram_we_n(we_n_1), .sram_adr(adr_1),
    .sram_dout(dout_1), .sram_doe(doe_1), .sram_din(din_1));

  hmmm_sram_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_CYCLES(0)) u_d0 (
    .ph1(ph1), .ph2(ph2), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .ready(ready_0), .rdata(rdata_0), .rvalid(rvalid_0), .done(done_0),
    .sram_ce_n(ce_n_0), .sram_oe_n(oe_n_0), .sram_we_n(we_n_0), .sram_adr(adr_0),
    .sram_dout(dout_0), .sram_doe(doe_0), .sram_din(din_0));

  hmmm_sram_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_CYCLES(3)) u_d3 (
    .ph1(ph1), .ph2(ph2), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .ready(ready_3), .rdata(rdata_3), .rvalid(rvalid_3), .done(done_3),
    .sram_ce_n(ce_n_3), .sram_oe_n(oe_n_3), .sram_we_n(we_n_3), .sram_adr(adr_3),
    .sram_dout(dout_3), .sram_doe(doe_3), .sram_din(din_3));

  hmmm_sram_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_CYCLES(1)) u_dw (
    .ph1(ph1), .ph2(ph2), .reset(reset), .req(req), .wr(wr), .addr(waddr), .wdata(wwdata),
    .ready(ready_w), .rdata(rdata_w), .rvalid(rvalid_w), .done(done_w),
    .sram_ce_n(ce_n_w), .sram_oe_n(oe_n_w), .sram_we_n(we_n_w), .sram_adr(adr_w),
    .sram_dout(dout_w), .sram_doe(doe_w), .sram_din(din_w));

  // SRAM models: combinational read, write while ce_n/we_n low and bus driven
  assign din_1 = mem1[adr_1];
  assign din_0 = mem0[adr_0];
  assign din_3 = mem3[adr_3];
  assign din_w = memw[adr_w];

  always @(posedge ph2) begin
    if (!ce_n_1 && !we_n_1 && doe_1) mem1[adr_1] <= dout_1;
    if (!ce_n_0 && !we_n_0 && doe_0) mem0[adr_0] <= dout_0;
    if (!ce_n_3 && !we_n_3 && doe_3) mem3[adr_3] <= dout_3;
    if (!ce_n_w && !we_n_w && doe_w) memw[adr_w] <= dout_w;
  end

  // bus-contention watch on every instance
  always @(negedge ph1) begin
    if (mon_en) begin
      if ((!oe_n_1 && doe_1) || (!oe_n_1 && !we_n_1)) viol++;
      if ((!oe_n_0 && doe_0) || (!oe_n_0 && !we_n_0)) viol++;
      if ((!oe_n_3 && doe_3) || (!oe_n_3 && !we_n_3)) viol++;
      if ((!oe_n_w && doe_w) || (!oe_n_w && !we_n_w)) viol++;
    end
  end

  initial begin
    ph1 = 1'b0;
    ph2 = 1'b0;
    forever begin
      #1 ph1 = 1'b1;
      #4 ph1 = 1'b0;
      #6 ph2 = 1'b1;
      #4 ph2 = 1'b0;
      #5;
    end
  end

  task automatic tick;
    @(posedge ph1);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic write_all(input logic [7:0] a, input logic [15:0] d);
    req = 1'b1; wr = 1'b1; addr = a; wdata = d;
    tick;
    req = 1'b0;
    repeat (8) tick;
  endtask

  logic [9:0] exp_oe;
  logic [9:0] exp_rv;

  initial begin
    reset = 1'b1; req = 1'b1; wr = 1'b1;
    addr = 8'h00; wdata = 16'h0000; waddr = 10'h000; wwdata = 32'h0;

    // reset with req held high: must be ignored
    repeat (3) tick;
    reset = 1'b0; req = 1'b0; wr = 1'b0;
    mon_en = 1'b1;
    check("rst_ready", ready_1, 1);
    check("rst_ce_n", ce_n_1, 1);
    check("rst_oe_n", oe_n_1, 1);
    check("rst_we_n", we_n_1, 1);
    check("rst_doe", doe_1, 0);
    check("rst_done", done_1, 0);
    check("rst_rvalid", rvalid_1, 0);
    check("rst_rdata", rdata_1, 0);
    check("rst_adr", adr_1, 0);
    check("rst_dout", dout_1, 0);
    tick;
    check("rst_idle_ce_n", ce_n_1, 1);
    check("rst_idle_ready", ready_1, 1);

    // write 0x2D=0x00AB, WAIT=1
    req = 1'b1; wr = 1'b1; addr = 8'h2D; wdata = 16'h00AB;
    tick;
    req = 1'b0;
    check("w_setup_ce_n", ce_n_1, 0);
    check("w_setup_we_n", we_n_1, 1);
    check("w_setup_doe", doe_1, 1);
    check("w_setup_adr", adr_1, 8'h2D);
    check("w_setup_ready", ready_1, 0);
    tick;
    check("w_acc1_we_n", we_n_1, 0);
    check("w_acc1_oe_n", oe_n_1, 1);
    tick;
    check("w_acc2_we_n", we_n_1, 0);
    check("w_acc2_done", done_1, 0);
    tick;
    check("w_hold_done", done_1, 1);
    check("w_hold_we_n", we_n_1, 1);
    check("w_hold_ce_n", ce_n_1, 0);
    check("w_hold_doe", doe_1, 1);
    check("w_hold_ready", ready_1, 0);
    tick;
    check("w_idle_done", done_1, 0);
    check("w_idle_ready", ready_1, 1);
    check("w_idle_ce_n", ce_n_1, 1);
    check("w_dout_held", dout_1, 16'h00AB);
    check("w_mem", mem1[8'h2D], 16'h00AB);
    repeat (6) tick;

    // read 0x2D, WAIT=0
    req = 1'b1; wr = 1'b0; addr = 8'h2D;
    tick;
    req = 1'b0;
    check("r0_acc_oe_n", oe_n_0, 0);
    check("r0_acc_doe", doe_0, 0);
    check("r0_acc_rvalid", rvalid_0, 0);
    tick;
    check("r0_turn_oe_n", oe_n_0, 1);
    check("r0_turn_rvalid", rvalid_0, 1);
    check("r0_turn_done", done_0, 1);
    check("r0_turn_rdata", rdata_0, 16'h00AB);
    tick;
    check("r0_idle_rvalid", rvalid_0, 0);
    check("r0_rdata_held", rdata_0, 16'h00AB);
    repeat (6) tick;

    // preload via the controllers themselves
    write_all(8'h10, 16'h1234);
    write_all(8'h11, 16'h5678);
    write_all(8'h20, 16'h0C0C);

    // back-to-back reads, WAIT=3
    exp_oe = 10'b10_0001_0000;
    exp_rv = 10'b10_0001_0000;
    req = 1'b1; wr = 1'b0; addr = 8'h10;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (i == 0) addr = 8'h11;
      if (i == 5) req = 1'b0;
      check($sformatf("b2b_oe_n_c%0d", i + 1), oe_n_3, exp_oe[i]);
      check($sformatf("b2b_rvalid_c%0d", i + 1), rvalid_3, exp_rv[i]);
      if (i == 4) begin
        check("b2b_rdata1", rdata_3, 16'h1234);
        check("b2b_turn_ready", ready_3, 1);
      end
      if (i == 9) check("b2b_rdata2", rdata_3, 16'h5678);
    end
    repeat (4) tick;

    // read then write, WAIT=1
    req = 1'b1; wr = 1'b0; addr = 8'h20;
    tick;
    wr = 1'b1; addr = 8'h21; wdata = 16'hBEEF;
    tick;
    tick;
    check("rw_turn_rvalid", rvalid_1, 1);
    check("rw_turn_rdata", rdata_1, 16'h0C0C);
    check("rw_turn_oe_n", oe_n_1, 1);
    check("rw_turn_doe", doe_1, 0);
    tick;
    req = 1'b0;
    check("rw_setup_ce_n", ce_n_1, 0);
    check("rw_setup_we_n", we_n_1, 1);
    check("rw_setup_doe", doe_1, 1);
    check("rw_setup_adr", adr_1, 8'h21);
    repeat (4) tick;
    check("rw_mem", mem1[8'h21], 16'hBEEF);
    repeat (4) tick;

    // reset during second ACCESS cycle of a write
    req = 1'b1; wr = 1'b1; addr = 8'h30; wdata = 16'h1111;
    tick;
    req = 1'b0;
    tick;
    check("ra_acc1_we_n", we_n_1, 0);
    tick;
    reset = 1'b1;
    check("ra_acc2_we_n", we_n_1, 0);
    tick;
    reset = 1'b0;
    check("ra_ce_n", ce_n_1, 1);
    check("ra_we_n", we_n_1, 1);
    check("ra_doe", doe_1, 0);
    check("ra_done", done_1, 0);
    check("ra_ready", ready_1, 1);
    check("ra_rdata", rdata_1, 0);
    tick;
    check("ra_no_done", done_1, 0);
    check("ra_idle_ce_n", ce_n_1, 1);
    repeat (4) tick;

    // wide part at the top address
    req = 1'b1; wr = 1'b1; waddr = 10'h3FF; wwdata = 32'hDEADBEEF;
    tick;
    req = 1'b0;
    repeat (5) tick;
    check("wide_mem", memw[10'h3FF], 32'hDEADBEEF);
    req = 1'b1; wr = 1'b0;
    tick;
    req = 1'b0;
    check("wide_adr", adr_w, 10'h3FF);
    check("wide_oe_n", oe_n_w, 0);
    tick;
    tick;
    check("wide_rvalid", rvalid_w, 1);
    check("wide_rdata", rdata_w, 32'hDEADBEEF);
    repeat (3) tick;

    check("contention", viol, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
